// File: rtl/mem_fill_pkg.sv
// mem_fill_pkg: shared constants, requester ids and FSM encoding for the
// memory fill responder.
package mem_fill_pkg;

    localparam int   LINE_WORDS = 8;
    localparam logic RID_ICACHE = 1'b0;
    localparam logic RID_DCACHE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } fill_state_e;

    // Map a 15-bit word address (byte address >> 1) onto the array depth.
    function automatic int word_index(input logic [14:0] word_addr, input int words);
        return int'(word_addr) % words;
    endfunction

endpackage

// File: rtl/mem_fill_pipe.sv
// mem_fill_pipe: LATENCY-deep return pipeline carrying valid, requester id,
// word offset and read data. Stage 0 is loaded in the issue cycle, which is
// the same edge that loads the array's registered read port, so data_i is
// already aligned with stage 0 and only needs LATENCY-1 further registers.
module mem_fill_pipe #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        id_i,
    input  logic [2:0]  word_i,
    input  logic [15:0] data_i,
    output logic        valid_o,
    output logic        id_o,
    output logic [2:0]  word_o,
    output logic [15:0] data_o
);

    logic       valid_q [LATENCY];
    logic       id_q    [LATENCY];
    logic [2:0] word_q  [LATENCY];
    logic [15:0] data_tail;

    // Control stages: cleared by reset so an aborted burst never surfaces.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                valid_q[s] <= 1'b0;
                id_q[s]    <= 1'b0;
                word_q[s]  <= 3'd0;
            end
        end else begin
            valid_q[0] <= valid_i;
            id_q[0]    <= valid_i & id_i;
            word_q[0]  <= valid_i ? word_i : 3'd0;
            for (int s = 1; s < LATENCY; s++) begin
                valid_q[s] <= valid_q[s-1];
                id_q[s]    <= id_q[s-1];
                word_q[s]  <= word_q[s-1];
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_no_data_stages
            assign data_tail = data_i;
        end else begin : g_data_stages
            logic [15:0] data_q [LATENCY-1];
            // Data stages carry no reset; the output is masked by valid instead.
            always_ff @(posedge clk) begin
                data_q[0] <= data_i;
                for (int s = 1; s < LATENCY - 1; s++) begin
                    data_q[s] <= data_q[s-1];
                end
            end
            assign data_tail = data_q[LATENCY-2];
        end
    endgenerate

    assign valid_o = valid_q[LATENCY-1];
    assign id_o    = id_q[LATENCY-1];
    assign word_o  = word_q[LATENCY-1];
    assign data_o  = valid_o ? data_tail : 16'h0000;

endmodule

// File: rtl/mem_fill_responder.sv
// mem_fill_responder: arbitrates Icache/Dcache requests onto one 16-bit word
// array, returning 8-word line fills through a fixed-latency pipeline and
// performing single-word Dcache writes in the grant cycle.
// Optional macro MEM_FILL_CRITICAL_WORD_FIRST_EN: fill starts at the missed
// word and wraps within the line; otherwise words are returned 0..7.
// The array has no reset and relies on power-up zero contents.
module mem_fill_responder
    import mem_fill_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 32768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_gnt,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic [15:0] rdata,
    output logic        rvalid,
    output logic        rid,
    output logic [2:0]  rword,
    output logic        busy
);

    localparam int         AW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [2:0] LAST_WORD  = 3'(LINE_WORDS - 1);
    localparam logic [2:0] LAST_DRAIN = 3'(LATENCY - 1);

    fill_state_e   state_q;
    logic [2:0]    cnt_q;
    logic [11:0]   line_q;
    logic [2:0]    start_q;
    logic          id_q;
    logic          busy_q;

    logic          rd_grant;
    logic          wr_grant;
    logic [15:1]   sel_addr;
    logic          sel_id;
    logic [2:0]    first_word;
    logic          issue_valid;
    logic          issue_id;
    logic [11:0]   issue_line;
    logic [2:0]    issue_word;
    logic [AW-1:0] ram_addr;
    logic [15:0]   mem [MEM_WORDS];
    logic [15:0]   ram_rdata_q;
    logic          unused_addr_bits;

    assign unused_addr_bits = i_addr[0] ^ d_addr[0];

    // Grants are only offered in IDLE, Icache first; reset masks them at once.
    always_comb begin
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        if (state_q == ST_IDLE && !rst) begin
            i_gnt = i_req;
            d_gnt = d_req & ~i_req;
        end
        rd_grant = i_gnt | (d_gnt & ~d_wr);
        wr_grant = d_gnt & d_wr;
        sel_addr = i_req ? i_addr[15:1] : d_addr[15:1];
        sel_id   = i_req ? RID_ICACHE : RID_DCACHE;
    end

`ifdef MEM_FILL_CRITICAL_WORD_FIRST_EN
    assign first_word = sel_addr[3:1];
`else
    assign first_word = 3'd0;
`endif

    // Word 0 issues combinationally in the grant cycle, words 1..7 from ISSUE.
    always_comb begin
        issue_valid = 1'b0;
        issue_id    = 1'b0;
        issue_line  = sel_addr[15:4];
        issue_word  = first_word;
        case (state_q)
            ST_IDLE: begin
                issue_valid = rd_grant;
                issue_id    = sel_id;
            end
            ST_ISSUE: begin
                issue_valid = 1'b1;
                issue_id    = id_q;
                issue_line  = line_q;
                issue_word  = start_q + cnt_q;
            end
            default: ;
        endcase
        ram_addr = wr_grant ? AW'(word_index(sel_addr, MEM_WORDS))
                            : AW'(word_index({issue_line, issue_word}, MEM_WORDS));
    end

    // Burst sequencer: ISSUE counts words 1..7, DRAIN waits LATENCY cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            line_q  <= 12'd0;
            start_q <= 3'd0;
            id_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_grant) begin
                        state_q <= ST_ISSUE;
                        cnt_q   <= 3'd1;
                        line_q  <= sel_addr[15:4];
                        start_q <= first_word;
                        id_q    <= sel_id;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (cnt_q == LAST_WORD) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= 3'd0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_q == LAST_DRAIN) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 3'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 3'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Single-port word array with registered read; reads and writes never
    // share a cycle because writes are only granted in IDLE.
    always_ff @(posedge clk) begin
        if (wr_grant) begin
            mem[ram_addr] <= d_wdata;
        end
        ram_rdata_q <= mem[ram_addr];
    end

    mem_fill_pipe #(
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (issue_valid),
        .id_i    (issue_id),
        .word_i  (issue_word),
        .data_i  (ram_rdata_q),
        .valid_o (rvalid),
        .id_o    (rid),
        .word_o  (rword),
        .data_o  (rdata)
    );

    assign busy = busy_q;

endmodule

// File: tb/tb_mem_fill_responder.sv
// tb_mem_fill_responder: directed stimulus, a cycle-level behavioural model
// checked on every falling edge, plus literal expectations per scenario.
module tb_mem_fill_responder;

    localparam int L  = 4;
    localparam int MW = 32768;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_gnt;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic [15:0] rdata;
    logic        rvalid;
    logic        rid;
    logic [2:0]  rword;
    logic        busy;

    always #5 clk = ~clk;

    mem_fill_responder #(
        .LATENCY   (L),
        .MEM_WORDS (MW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .d_req   (d_req),
        .d_wr    (d_wr),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rid     (rid),
        .rword   (rword),
        .busy    (busy)
    );

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] mem_m  [int];
    logic [15:0] e_data [int];
    logic        e_id   [int];
    logic [2:0]  e_word [int];
    int          next_free = 0;
    int          busy_lo   = 1;
    int          busy_hi   = 0;
    bit          m_idle, m_gi, m_gd, m_ev, m_busy;
    logic [15:0] m_a, m_ed;
    logic        m_eid;
    logic [2:0]  m_ew;
    int          m_start, m_w, m_idx;

    function automatic logic [15:0] mem_rd(input int idx);
        if (mem_m.exists(idx)) return mem_m[idx];
        return 16'h0000;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            e_data.delete();
            e_id.delete();
            e_word.delete();
            next_free = 0;
            busy_lo   = 1;
            busy_hi   = 0;
        end
        m_idle = !rst && (cyc >= next_free);
        m_gi   = m_idle && i_req;
        m_gd   = m_idle && d_req && !i_req;
        m_ev   = e_data.exists(cyc);
        m_ed   = 16'h0000;
        m_eid  = 1'b0;
        m_ew   = 3'd0;
        if (m_ev) begin
            m_ed  = e_data[cyc];
            m_eid = e_id[cyc];
            m_ew  = e_word[cyc];
        end
        m_busy = !rst && cyc >= busy_lo && cyc <= busy_hi;
        check("m_i_gnt",  32'(i_gnt),  32'(m_gi));
        check("m_d_gnt",  32'(d_gnt),  32'(m_gd));
        check("m_rvalid", 32'(rvalid), 32'(m_ev));
        check("m_rdata",  32'(rdata),  32'(m_ed));
        check("m_rid",    32'(rid),    32'(m_eid));
        check("m_rword",  32'(rword),  32'(m_ew));
        check("m_busy",   32'(busy),   32'(m_busy));
        if (m_gi || (m_gd && !d_wr)) begin
            m_a = m_gi ? i_addr : d_addr;
`ifdef MEM_FILL_CRITICAL_WORD_FIRST_EN
            m_start = int'(m_a[3:1]);
`else
            m_start = 0;
`endif
            for (int k = 0; k < 8; k++) begin
                m_w   = (m_start + k) % 8;
                m_idx = ((int'(m_a) >> 4) * 8 + m_w) % MW;
                e_data[cyc + k + L] = mem_rd(m_idx);
                e_id[cyc + k + L]   = m_gi ? 1'b0 : 1'b1;
                e_word[cyc + k + L] = 3'(m_w);
            end
            busy_lo   = cyc + 1;
            busy_hi   = cyc + L + 7;
            next_free = cyc + L + 8;
        end else if (m_gd && d_wr) begin
            mem_m[(int'(d_addr) >> 1) % MW] = d_wdata;
        end
    end

    // ---------------- beat recorder for literal checks ----------------
    typedef struct {
        int          c;
        logic [15:0] d;
        logic        id;
        logic [2:0]  w;
    } beat_t;
    beat_t beats[$];
    beat_t bt;

    always @(negedge clk) begin
        if (rvalid) begin
            bt.c  = cyc;
            bt.d  = rdata;
            bt.id = rid;
            bt.w  = rword;
            beats.push_back(bt);
        end
    end

    // ---------------- directed stimulus ----------------
    int t0, r0;
    int exp_w [8];

    initial begin
`ifdef MEM_FILL_CRITICAL_WORD_FIRST_EN
        exp_w = '{3, 4, 5, 6, 7, 0, 1, 2};
`else
        exp_w = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        rst = 1'b1; i_req = 1'b1; i_addr = 16'h1230;
        d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
        @(negedge clk);
        check("rst_i_gnt",  32'(i_gnt),  32'd0);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata",  32'(rdata),  32'd0);
        tick(); tick();
        rst = 1'b0; i_req = 1'b0;
        tick();

        // Icache fill of line 0x1230
        i_req = 1'b1; i_addr = 16'h1230; t0 = cyc; beats.delete();
        @(negedge clk);
        check("t1_i_gnt", 32'(i_gnt), 32'd1);
        check("t1_d_gnt", 32'(d_gnt), 32'd0);
        tick(); i_req = 1'b0;
        while (cyc < t0 + 12) tick();
        @(negedge clk);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_beats", 32'(beats.size()), 32'd8);
        if (beats.size() >= 8) begin
            check("t1_first_cyc", 32'(beats[0].c), 32'(t0 + 4));
            check("t1_last_cyc",  32'(beats[7].c), 32'(t0 + 11));
            for (int k = 0; k < 8; k++) begin
                check("t1_rword", 32'(beats[k].w),  32'(k));
                check("t1_rid",   32'(beats[k].id), 32'd0);
                check("t1_rdata", 32'(beats[k].d),  32'h0);
            end
        end

        // Dcache write then Dcache fill of the same line
        tick();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0042; d_wdata = 16'hBEEF;
        @(negedge clk);
        check("t2_wr_gnt",  32'(d_gnt), 32'd1);
        check("t2_wr_busy", 32'(busy),  32'd0);
        tick();
        d_wr = 1'b0; d_addr = 16'h0040; t0 = cyc; beats.delete();
        @(negedge clk);
        check("t2_rd_gnt", 32'(d_gnt), 32'd1);
        tick(); d_req = 1'b0;
        while (cyc < t0 + 12) tick();
        check("t2_beats", 32'(beats.size()), 32'd8);
        if (beats.size() >= 8) begin
            check("t2_word0", 32'(beats[0].d),  32'h0000);
            check("t2_word1", 32'(beats[1].d),  32'hBEEF);
            check("t2_rid",   32'(beats[1].id), 32'd1);
            check("t2_first", 32'(beats[0].c),  32'(t0 + 4));
        end

        // Simultaneous requests: Icache wins, Dcache waits for T+12
        tick();
        i_req = 1'b1; i_addr = 16'h0100; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
        t0 = cyc; beats.delete();
        @(negedge clk);
        check("t3_i_gnt", 32'(i_gnt), 32'd1);
        check("t3_d_gnt", 32'(d_gnt), 32'd0);
        tick(); i_req = 1'b0;
        while (cyc < t0 + 11) tick();
        @(negedge clk);
        check("t3_d_wait", 32'(d_gnt), 32'd0);
        tick();
        @(negedge clk);
        check("t3_d_gnt_t12", 32'(d_gnt), 32'd1);
        tick(); d_req = 1'b0;
        while (cyc < t0 + 25) tick();
        check("t3_beats", 32'(beats.size()), 32'd16);
        if (beats.size() >= 16) begin
            check("t3_i_id",    32'(beats[7].id), 32'd0);
            check("t3_d_id",    32'(beats[8].id), 32'd1);
            check("t3_d_start", 32'(beats[8].c),  32'(t0 + 16));
            check("t3_d_word1", 32'(beats[9].d),  32'hBEEF);
        end

        // Word order for a mid-line miss
        tick();
        i_req = 1'b1; i_addr = 16'h1236; t0 = cyc; beats.delete();
        tick(); i_req = 1'b0;
        while (cyc < t0 + 12) tick();
        check("t4_beats", 32'(beats.size()), 32'd8);
        if (beats.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                check("t4_rword", 32'(beats[k].w), 32'(exp_w[k]));
            end
        end

        // Reset in the middle of a burst
        tick();
        i_req = 1'b1; i_addr = 16'h1230; t0 = cyc; beats.delete();
        tick(); i_req = 1'b0;
        while (cyc < t0 + 6) tick();
        rst = 1'b1;
        #1;
        check("t5_rvalid_async", 32'(rvalid), 32'd0);
        check("t5_busy_async",   32'(busy),   32'd0);
        i_req = 1'b1; i_addr = 16'h2000;
        @(negedge clk);
        check("t5_gnt_in_rst", 32'(i_gnt), 32'd0);
        tick(); tick();
        rst = 1'b0; r0 = cyc;
        @(negedge clk);
        check("t5_regrant", 32'(i_gnt), 32'd1);
        tick(); i_req = 1'b0;
        while (cyc < r0 + 12) tick();
        check("t5_beats", 32'(beats.size()), 32'd10);
        if (beats.size() >= 3) begin
            check("t5_pre_rst", 32'(beats[1].c), 32'(t0 + 5));
            check("t5_resume",  32'(beats[2].c), 32'(r0 + 4));
        end

        // Dcache write held off while a burst is in flight
        tick();
        i_req = 1'b1; i_addr = 16'h0300; t0 = cyc; beats.delete();
        tick(); i_req = 1'b0;
        tick();
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0302; d_wdata = 16'h1234;
        while (cyc < t0 + 11) tick();
        @(negedge clk);
        check("t6_d_held", 32'(d_gnt), 32'd0);
        tick();
        @(negedge clk);
        check("t6_d_gnt", 32'(d_gnt), 32'd1);
        tick(); d_req = 1'b0; d_wr = 1'b0;
        check("t6_beats", 32'(beats.size()), 32'd8);
        if (beats.size() >= 8) begin
            check("t6_unchanged", 32'(beats[1].d), 32'h0000);
        end

        // Read back the delayed write
        d_req = 1'b1; d_addr = 16'h0300; t0 = cyc; beats.delete();
        @(negedge clk);
        check("t7_gnt", 32'(d_gnt), 32'd1);
        tick(); d_req = 1'b0;
        while (cyc < t0 + 12) tick();
        check("t7_beats", 32'(beats.size()), 32'd8);
        if (beats.size() >= 8) begin
            check("t7_word1", 32'(beats[1].d), 32'h1234);
            check("t7_rword", 32'(beats[1].w), 32'd1);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_fill_responder.md
MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, giving read latency in cycles (legal 1..8).
REQ-002 SHALL have parameter MEM_WORDS, default 32768, giving the 16-bit word array depth.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1, the single clock.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port i_req, input, 1, Icache line-fill request, held until granted.
REQ-007 Port i_addr, input, 16, Icache miss byte address.
REQ-008 Port i_gnt, output, 1, Icache request accepted this cycle.
REQ-009 Port d_req, input, 1, Dcache request (fill or write), held until granted.
REQ-010 Port d_wr, input, 1, Dcache request is a single-word write.
REQ-011 Port d_addr, input, 16, Dcache byte address.
REQ-012 Port d_wdata, input, 16, Dcache write data.
REQ-013 Port d_gnt, output, 1, Dcache request accepted this cycle.
REQ-014 Port rdata, output, 16, returned fill word.
REQ-015 Port rvalid, output, 1, rdata/rid/rword valid this cycle.
REQ-016 Port rid, output, 1, requester of the returned word: 0 = Icache, 1 = Dcache.
REQ-017 Port rword, output, 3, word offset of rdata within the 16-byte line.
REQ-018 Port busy, output, 1, a fill burst is in flight.

Function
REQ-019 SHALL use states IDLE, ISSUE and DRAIN.
REQ-020 SHALL drive i_gnt = i_req in IDLE, and 0 in all other states.
REQ-021 SHALL drive d_gnt = d_req & ~i_req in IDLE (Icache priority), and 0 in all other states.
REQ-022 A granted read (i_req, or d_req with d_wr = 0) in cycle T SHALL move IDLE->ISSUE and read word k of the line at cycle T+k, for k = 0..7.
REQ-023 After issuing word 7, the FSM SHALL move ISSUE->DRAIN, and DRAIN->IDLE once the pipeline is empty.
REQ-024 Word k SHALL appear with rvalid = 1 at cycle T+k+LATENCY, with rid equal to the granted requester; a burst is exactly 8 consecutive rvalid cycles.
REQ-025 busy SHALL be 1 from T+1 through T+LATENCY+7; the earliest next grant is T+LATENCY+8.
REQ-026 A granted write in cycle T SHALL write d_wdata to word d_addr[15:1] at the clock edge ending cycle T, produce no rvalid and leave busy at 0; the next grant is possible at T+1.
REQ-027 The line base address SHALL be {addr[15:4], 4'b0}, and the word index SHALL be addr[15:1] modulo MEM_WORDS.
REQ-028 When rvalid = 0, rdata, rid and rword SHALL be 0.
REQ-029 A read of a word never written SHALL return 16'h0000.

Reset
REQ-030 Reset SHALL force state IDLE and rvalid, busy, i_gnt, d_gnt, rdata, rid and rword to 0, asynchronously.
REQ-031 Reset during ISSUE or DRAIN SHALL abort the burst: no further rvalid until a new grant.
REQ-032 Reset SHALL NOT alter the memory array contents.

Configuration
REQ-033 Macro MEM_FILL_CRITICAL_WORD_FIRST_EN SHALL select the fill word order.
REQ-034 With the macro defined, the word issued at offset k SHALL be (addr[3:1]+k) mod 8, wrapping within the line.
REQ-035 Without the macro, the word issued at offset k SHALL be k, with order 0..7 regardless of addr[3:1].

Structure
REQ-036 Package mem_fill_pkg SHALL hold LINE_WORDS = 8, RID_ICACHE = 0, RID_DCACHE = 1 and the state encoding.
REQ-037 Sub-module mem_fill_pipe SHALL implement the LATENCY-deep valid/id/word/data shift pipeline.

Verification
REQ-038 Reset, then i_req with i_addr = 16'h1230 -> i_gnt = 1 at T; rvalid at T+4..T+11; rid = 0; rword 0..7; busy 0 at T+12.
REQ-039 Dcache write 16'hBEEF at 16'h0042, then d_req read of 16'h0040 -> d_gnt at the write cycle and the next cycle; word 1 of the burst = 16'hBEEF; rid = 1.
REQ-040 i_req and d_req raised in the same IDLE cycle -> i_gnt = 1 and d_gnt = 0; d_gnt = 1 at T+12; the D burst follows.
REQ-041 Macro defined, i_addr = 16'h1236 -> rword sequence 3,4,5,6,7,0,1,2; macro undefined -> 0..7.
REQ-042 rst asserted at T+6 of a burst -> rvalid and busy 0 immediately; no rvalid afterwards; a new i_req is granted in the cycle after rst is released.
REQ-043 d_req write while busy = 1 -> d_gnt held at 0 and memory unchanged until IDLE; then granted.
